m_mem_ctrl: RTL and testbench

M-stage data-memory access controller. Sequences each load/store of the M-stage instruction onto a variable-latency data bus using a request/grant/response handshake. It stalls the pipeline until the access completes, generates byte enables and lane-replicated write data, and returns extracted, extended load data. Misaligned accesses are flagged as exceptions and never reach the bus.

---
 rtl/mem_ctrl_pkg.sv | 38 +++
 rtl/m_load_ext.sv | 38 +++
 rtl/m_mem_ctrl.sv | 126 ++++++++++++
 tb/tb_m_mem_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared op codes, FSM state type and bus request record for the M-stage
// data-memory controller.
package mem_ctrl_pkg;

  localparam logic [3:0] DM_NONE = 4'd0;
  localparam logic [3:0] DM_SB   = 4'd1;
  localparam logic [3:0] DM_SH   = 4'd2;
  localparam logic [3:0] DM_SW   = 4'd3;
  localparam logic [3:0] DM_LB   = 4'd4;
  localparam logic [3:0] DM_LH   = 4'd5;
  localparam logic [3:0] DM_LW   = 4'd6;
  localparam logic [3:0] DM_LBU  = 4'd7;
  localparam logic [3:0] DM_LHU  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } bus_cmd_t;

  function automatic logic is_store(input logic [3:0] op);
    return (op == DM_SB) || (op == DM_SH) || (op == DM_SW);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == DM_LB) || (op == DM_LH) || (op == DM_LW) ||
           (op == DM_LBU) || (op == DM_LHU);
  endfunction

endpackage

// File: rtl/m_load_ext.sv
// Selects the addressed byte/halfword of a loaded word and sign/zero extends it.
module m_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    case (off)
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
  end

  assign h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = '0;
    case (op)
      DM_LB:   result = {{24{b[7]}}, b};
      DM_LBU:  result = {24'd0, b};
      DM_LH:   result = {{16{h[15]}}, h};
      DM_LHU:  result = {16'd0, h};
      DM_LW:   result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage load/store sequencer: req/gnt/rvalid bus handshake, pipeline stall,
// byte enables, lane-replicated store data and extended load results.
module m_mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [3:0]  DM_Op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  bus_cmd_t    cmd_q, cmd_d;
  logic        ld, st, active, misal, start;
  logic [31:0] ext;

  assign ld     = is_load(DM_Op);
  assign st     = is_store(DM_Op);
  assign active = m_valid && (ld || st);

  always_comb begin
    misal = 1'b0;
    case (DM_Op)
      DM_SH, DM_LH, DM_LHU: misal = addr[0];
      DM_SW, DM_LW:         misal = (addr[1:0] != 2'b00);
      default:              misal = 1'b0;
    endcase
  end

  assign exc_adel = active && ld && misal;
  assign exc_ades = active && st && misal;
  assign start    = (state == S_IDLE) && active && !misal;
  assign stall    = start || (state == S_REQ) || (state == S_WAIT);
  assign done     = (state == S_DONE);

  // Bus command as it will be presented for the whole REQ phase
  always_comb begin
    cmd_d.we     = st;
    cmd_d.addr   = {addr[31:2], 2'b00};
    cmd_d.byteen = 4'b0000;
    cmd_d.wdata  = '0;
    case (DM_Op)
      DM_SB: begin
        cmd_d.byteen = 4'b0001 << addr[1:0];
        cmd_d.wdata  = {4{wdata[7:0]}};
      end
      DM_SH: begin
        cmd_d.byteen = addr[1] ? 4'b1100 : 4'b0011;
        cmd_d.wdata  = {2{wdata[15:0]}};
      end
      DM_SW: begin
        cmd_d.byteen = 4'b1111;
        cmd_d.wdata  = wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)      state_nxt = S_REQ;
      S_REQ:   if (bus_gnt)    state_nxt = S_WAIT;
      S_WAIT:  if (bus_rvalid) state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  m_load_ext u_load_ext (
    .op     (op_q),
    .off    (off_q),
    .rdata  (bus_rdata),
    .result (ext)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= DM_NONE;
      off_q     <= 2'b00;
      cmd_q     <= '0;
      bus_req   <= 1'b0;
      rdata_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q    <= DM_Op;
          off_q   <= addr[1:0];
          cmd_q   <= cmd_d;
          bus_req <= 1'b1;
        end
        S_REQ:  if (bus_gnt)    bus_req   <= 1'b0;
        S_WAIT: if (bus_rvalid) rdata_out <= ext;
        default: ;
      endcase
    end
  end

  assign bus_we     = cmd_q.we;
  assign bus_addr   = cmd_q.addr;
  assign bus_byteen = cmd_q.byteen;
  assign bus_wdata  = cmd_q.wdata;

endmodule

// File: tb/tb_m_mem_ctrl.sv
// Self-checking bench for m_mem_ctrl: a bus responder with programmable
// gnt/rvalid delay and a queue of expected load results.
module tb_m_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [3:0]  DM_Op;
  logic [31:0] addr, wdata;
  logic        stall, done, exc_adel, exc_ades;
  logic [31:0] rdata_out;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_byteen;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  m_mem_ctrl dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .DM_Op(DM_Op),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done),
    .rdata_out(rdata_out), .exc_adel(exc_adel), .exc_ades(exc_ades),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One aligned access; inputs driven at negedge, outputs sampled just after.
  task automatic access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int gd, input int rdly,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd,
                        input logic [31:0] exp_res);
    int cyc, stalls, reqs, wcnt;
    bit granted, finished;
    logic we;
    we = is_store(op);
    @(negedge clk);
    m_valid = 1'b1; DM_Op = op; addr = a; wdata = wd; bus_rdata = rd;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    #1;
    chk("stall_c0", {31'd0, stall}, 32'd1);
    chk("req_c0", {31'd0, bus_req}, 32'd0);
    if (!we) exp_q.push_back(exp_res);
    stalls = 1; reqs = 0; wcnt = 0; cyc = 0;
    granted = 1'b0; finished = 1'b0;
    while (!finished && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (stall) stalls++;
      if (done) begin
        finished = 1'b1;
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("done_cycle", cyc, 3 + gd + rdly);
        chk("stall_cycles", stalls, 3 + gd + rdly);
        chk("req_cycles", reqs, gd + 1);
        if (!we) begin
          if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
          else chk("rdata_out", rdata_out, exp_q.pop_front());
        end
        m_valid = 1'b0; DM_Op = DM_NONE; bus_rvalid = 1'b0;
      end else if (!granted) begin
        chk("req_held", {31'd0, bus_req}, 32'd1);
        if (reqs == 0) begin
          chk("bus_addr", bus_addr, {a[31:2], 2'b00});
          chk("bus_we", {31'd0, bus_we}, {31'd0, we});
          chk("bus_byteen", {28'd0, bus_byteen}, {28'd0, exp_be});
          if (we) chk("bus_wdata", bus_wdata, exp_wd);
        end
        bus_gnt = (reqs == gd);
        granted = bus_gnt;
        reqs++;
        // Inputs wander during the access; the latched command must not follow.
        addr = 32'hFFFF_FFF0; wdata = 32'h0BAD_0BAD;
      end else begin
        bus_gnt = 1'b0;
        chk("req_wait", {31'd0, bus_req}, 32'd0);
        chk("stall_wait", {31'd0, stall}, 32'd1);
        bus_rvalid = (wcnt == rdly);
        wcnt++;
      end
    end
    if (!finished) chk("access_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("idle_after", {31'd0, stall | done | bus_req}, 32'd0);
  endtask

  task automatic misaligned(input logic [3:0] op, input logic [31:0] a,
                            input logic el, input logic es);
    @(negedge clk);
    m_valid = 1'b1; DM_Op = op; addr = a; wdata = 32'h1;
    #1;
    chk("exc_adel", {31'd0, exc_adel}, {31'd0, el});
    chk("exc_ades", {31'd0, exc_ades}, {31'd0, es});
    chk("mis_stall", {31'd0, stall}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mis_req", {31'd0, bus_req | done}, 32'd0);
    end
    m_valid = 1'b0; DM_Op = DM_NONE;
  endtask

  initial begin
    reset = 1'b1; m_valid = 1'b0; DM_Op = DM_NONE; addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_byteen", {28'd0, bus_byteen}, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_exc", {30'd0, exc_adel, exc_ades}, 32'd0);

    //     op      addr          wdata         rdata         gd rd  be       wdata exp      result
    access(DM_SW,  32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 32'h0);
    access(DM_SB,  32'h103, 32'h12345678, 32'h0,        2, 0, 4'b1000, 32'h78787878, 32'h0);
    access(DM_LB,  32'h202, 32'h0,        32'h11803344, 0, 0, 4'b0000, 32'h0, 32'hFFFFFF80);
    access(DM_LBU, 32'h202, 32'h0,        32'h11803344, 0, 1, 4'b0000, 32'h0, 32'h00000080);
    access(DM_LH,  32'h302, 32'h0,        32'h8001FFFF, 1, 0, 4'b0000, 32'h0, 32'hFFFF8001);
    access(DM_LHU, 32'h302, 32'h0,        32'h8001FFFF, 0, 0, 4'b0000, 32'h0, 32'h00008001);
    access(DM_LH,  32'h300, 32'h0,        32'h0000ABCD, 0, 0, 4'b0000, 32'h0, 32'hFFFFABCD);
    access(DM_LW,  32'h400, 32'h0,        32'hCAFEF00D, 1, 2, 4'b0000, 32'h0, 32'hCAFEF00D);
    access(DM_SH,  32'h206, 32'hAAAA1234, 32'h0,        0, 0, 4'b1100, 32'h12341234, 32'h0);
    access(DM_SB,  32'h201, 32'h000000A5, 32'h0,        0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0);
    access(DM_LB,  32'h200, 32'h0,        32'h8080807F, 0, 0, 4'b0000, 32'h0, 32'h0000007F);

    misaligned(DM_LW, 32'h101, 1'b1, 1'b0);
    misaligned(DM_SH, 32'h001, 1'b0, 1'b1);
    misaligned(DM_SW, 32'h102, 1'b0, 1'b1);

    // Op codes 9-15 are not accesses.
    @(negedge clk);
    m_valid = 1'b1; DM_Op = 4'd12; addr = 32'h3;
    #1;
    chk("op12_stall", {31'd0, stall}, 32'd0);
    chk("op12_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
    m_valid = 1'b0; DM_Op = DM_NONE;

    // Reset in WAIT with rvalid pending; a late rvalid must be ignored.
    @(negedge clk);
    m_valid = 1'b1; DM_Op = DM_LW; addr = 32'h500; bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("rst_mid_req", {31'd0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("rst_mid_wait", {31'd0, stall & ~bus_req}, 32'd1);
    bus_rvalid = 1'b1; reset = 1'b1; m_valid = 1'b0; DM_Op = DM_NONE;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_req0", {31'd0, bus_req}, 32'd0);
    chk("rst_mid_done0", {31'd0, done}, 32'd0);
    chk("rst_mid_rdata", rdata_out, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("late_rvalid", {31'd0, done | stall}, 32'd0);
      chk("late_rdata", rdata_out, 32'd0);
    end
    bus_rvalid = 1'b0;

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
